// File: rtl/uvme_clk_st_pkg.sv
// Shared types and default sizing for the clock-period monitor slice.
// Imported by the monitor top and its synchronizer/edge-detector sub-module.
package uvme_clk_st_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_STALLED = 2'd3
  } mon_state_e;

endpackage

// File: rtl/uvme_clk_st_edge_det.sv
// Brings the asynchronous observed clock into the clk domain and flags its rising edges.
// The rise flag is high for exactly one clk cycle per synchronized low-to-high transition.
module uvme_clk_st_edge_det
  import uvme_clk_st_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic obs_clk,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // Synchronizer chain plus one history flop for the edge compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], obs_clk};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/uvme_clk_st_period_mon.sv
// Passive monitor measuring the period of obs_clk in clk cycles, flagging out-of-tolerance
// periods and stalls (no edge within timeout cycles).
module uvme_clk_st_period_mon
  import uvme_clk_st_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             obs_clk,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tolerance,
  input  logic [CNT_W-1:0] timeout,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             mismatch,
  output logic             stall,
  output logic [31:0]      edge_count,
  output mon_state_e       state
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Absolute difference one bit wider than the operands so nothing wraps
  function automatic logic [CNT_W:0] abs_dev(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b);
    logic [CNT_W:0] wa;
    logic [CNT_W:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    if (wa >= wb) begin
      abs_dev = wa - wb;
    end else begin
      abs_dev = wb - wa;
    end
  endfunction

  logic             rise;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  mon_state_e       state_nxt;
  logic             take;
  logic             over_tol;
  logic             count_edge;

  uvme_clk_st_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_det (
    .clk    (clk),
    .reset_n(reset_n),
    .obs_clk(obs_clk),
    .rise   (rise)
  );

  assign over_tol   = abs_dev(cnt_r, exp_period) > {1'b0, tolerance};
  assign count_edge = rise & en & (state != ST_IDLE);

  // Next-state and interval-counter logic; take marks a completed measurement
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_r;
    take      = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt   = '0;
          state_nxt = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (rise) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_MEASURE;
          end else begin
            cnt_nxt   = '0;
          end
        end
        ST_MEASURE: begin
          // An edge landing on the timeout cycle still counts as a valid period
          if (rise) begin
            take    = 1'b1;
            cnt_nxt = CNT_ONE;
          end else if ((timeout != '0) && (cnt_r == timeout)) begin
            state_nxt = ST_STALLED;
          end else if (cnt_r != CNT_MAX) begin
            cnt_nxt = cnt_r + CNT_ONE;
          end else begin
            cnt_nxt = cnt_r;
          end
        end
        ST_STALLED: begin
          if (rise) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_MEASURE;
          end else begin
            cnt_nxt   = cnt_r;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt_r        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      mismatch     <= 1'b0;
      stall        <= 1'b0;
      edge_count   <= 32'd0;
    end else begin
      state        <= state_nxt;
      cnt_r        <= cnt_nxt;
      period_valid <= take;
      mismatch     <= take & over_tol;
      stall        <= (state_nxt == ST_STALLED);
      if (take) begin
        period <= cnt_r;
      end
      if (count_edge && (edge_count != 32'hFFFF_FFFF)) begin
        edge_count <= edge_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uvme_clk_st_period_mon.sv
// Self-checking bench for uvme_clk_st_period_mon: an interval model of the driven obs_clk
// pushes expected periods to a scoreboard that is popped on every period_valid.
module tb_uvme_clk_st_period_mon;
  import uvme_clk_st_pkg::*;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic             obs_clk;
  logic [CNT_W-1:0] exp_period = '0;
  logic [CNT_W-1:0] tolerance = '0;
  logic [CNT_W-1:0] timeout = '0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             mismatch;
  logic             stall;
  logic [31:0]      edge_count;
  mon_state_e       state;

  uvme_clk_st_period_mon #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .obs_clk(obs_clk),
    .exp_period(exp_period), .tolerance(tolerance), .timeout(timeout),
    .period(period), .period_valid(period_valid), .mismatch(mismatch),
    .stall(stall), .edge_count(edge_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { int per; int expp; int tol; bit exp_mm; } vec_t;
  typedef struct { int per; bit mm; } sb_t;

  vec_t vecs[6];
  sb_t  sb_q[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   row_valid = 0;
  bit   row_mm = 1'b0;
  bit   stall_seen = 1'b0;

  // obs_clk sources: free-running generator or hand-driven level
  bit   gen_on = 1'b0;
  int   gen_per = 10;
  int   ph = 0;
  logic obs_gen = 1'b0;
  logic obs_man = 1'b0;
  assign obs_clk = gen_on ? obs_gen : obs_man;

  always @(negedge clk) begin
    if (gen_on) begin
      ph      <= (ph + 1 >= gen_per) ? 0 : ph + 1;
      obs_gen <= (ph >= gen_per / 2);
    end else begin
      ph      <= 0;
      obs_gen <= 1'b0;
    end
  end

  function automatic int sat_cnt(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function bit mm_of(int p);
    int d;
    d = p - int'(exp_period);
    if (d < 0) d = -d;
    return d > int'(tolerance);
  endfunction

  // Reference model: period = clk cycles between driven rises; gaps beyond timeout are discarded
  int last_rise = 0;
  bit have_prev = 1'b0;
  int exp_edges = 0;
  always @(posedge obs_clk or negedge reset_n or negedge en) begin
    if (!reset_n) begin
      have_prev <= 1'b0;
      exp_edges <= 0;
    end else if (!en) begin
      have_prev <= 1'b0;
    end else begin
      exp_edges <= exp_edges + 1;
      last_rise <= cyc;
      have_prev <= 1'b1;
      if (have_prev && (timeout == '0 || (cyc - last_rise) <= int'(timeout)))
        sb_q.push_back('{sat_cnt(cyc - last_rise), mm_of(sat_cnt(cyc - last_rise))});
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset_n) sb_q.delete();
    if (stall) stall_seen = 1'b1;
    chk("mismatch_without_valid", 64'(mismatch & ~period_valid), 64'd0);
    if (period_valid) begin
      row_valid++;
      if (mismatch) row_mm = 1'b1;
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 64'(sb_q.size() == 0), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("period", 64'(period), 64'(e.per));
        chk("mismatch", 64'(mismatch), 64'(e.mm));
      end
    end
  endtask

  int c_rise = 0;
  task automatic pulse(int hi, int lo);
    obs_man = 1'b1;
    c_rise = cyc;
    repeat (hi) tick();
    obs_man = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_stall(int bound);
    int k;
    k = 0;
    while (!stall && k < bound) begin
      tick();
      k++;
    end
  endtask

  initial begin
    vecs[0] = '{10, 10, 0, 1'b0};
    vecs[1] = '{12, 10, 1, 1'b1};
    vecs[2] = '{12, 10, 2, 1'b0};
    vecs[3] = '{8,  10, 2, 1'b0};
    vecs[4] = '{7,  10, 2, 1'b1};
    vecs[5] = '{20, 10, 5, 1'b1};

    // Reset state
    repeat (2) tick();
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_valid", 64'(period_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_edge_count", 64'(edge_count), 64'd0);
    chk("rst_state", 64'(state), 64'(ST_IDLE));
    reset_n = 1'b1;
    repeat (2) tick();

    // Table-driven period / tolerance rows
    foreach (vecs[i]) begin
      exp_period = CNT_W'(vecs[i].expp);
      tolerance  = CNT_W'(vecs[i].tol);
      timeout    = '0;
      en = 1'b1;
      row_valid = 0;
      row_mm = 1'b0;
      tick();
      gen_per = vecs[i].per;
      gen_on = 1'b1;
      repeat (6 * vecs[i].per + 3) tick();
      gen_on = 1'b0;
      repeat (8) tick();
      chk("row_sb_drained", 64'(sb_q.size()), 64'd0);
      chk("row_valid_count_ge4", 64'(row_valid >= 4), 64'd1);
      chk("row_mismatch_seen", 64'(row_mm), 64'(vecs[i].exp_mm));
      chk("row_period", 64'(period), 64'(vecs[i].per));
      chk("row_edge_count", 64'(edge_count), 64'(exp_edges));
      en = 1'b0;
      tick();
      chk("row_idle", 64'(state), 64'(ST_IDLE));
      chk("row_period_kept", 64'(period), 64'(vecs[i].per));
    end

    // Timeout: stall appears exactly SYNC+1+timeout cycles after the last driven rise
    exp_period = 8'd10; tolerance = 8'd0; timeout = 8'd50;
    en = 1'b1;
    repeat (2) tick();
    repeat (4) pulse(5, 5);
    wait_stall(200);
    chk("stall_latency", 64'(cyc - c_rise), 64'(SYNC + 1 + 50));
    chk("stalled_state", 64'(state), 64'(ST_STALLED));
    pulse(5, 5);
    chk("restart_stall_clear", 64'(stall), 64'd0);
    chk("restart_state", 64'(state), 64'(ST_MEASURE));
    pulse(5, 5);
    repeat (4) tick();
    chk("restart_sb_drained", 64'(sb_q.size()), 64'd0);

    // Edge on the timeout cycle wins: period 50 with timeout 50 never stalls
    stall_seen = 1'b0;
    repeat (3) pulse(25, 25);
    chk("edge_wins_no_stall", 64'(stall_seen), 64'd0);
    chk("edge_wins_period", 64'(period), 64'd50);

    // Disable while stalled
    wait_stall(200);
    chk("stall_before_disable", 64'(stall), 64'd1);
    en = 1'b0;
    tick();
    chk("disable_stall_clear", 64'(stall), 64'd0);
    chk("disable_idle", 64'(state), 64'(ST_IDLE));
    chk("disable_period_kept", 64'(period), 64'd50);

    // Held-high obs_clk with timeout off: counter saturates, no stall
    en = 1'b1; timeout = '0;
    repeat (2) tick();
    stall_seen = 1'b0;
    obs_man = 1'b1;
    repeat (300) tick();
    chk("sat_no_stall", 64'(stall_seen), 64'd0);
    chk("sat_state", 64'(state), 64'(ST_MEASURE));
    obs_man = 1'b0;
    repeat (3) tick();
    obs_man = 1'b1;
    repeat (6) tick();
    chk("sat_period", 64'(period), 64'(CMAX));
    chk("sat_edge_count", 64'(edge_count), 64'(exp_edges));
    obs_man = 1'b0;
    repeat (4) tick();

    // Asynchronous reset mid-interval
    gen_per = 10;
    gen_on = 1'b1;
    repeat (37) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_period", 64'(period), 64'd0);
    chk("arst_valid", 64'(period_valid), 64'd0);
    chk("arst_mismatch", 64'(mismatch), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_edge_count", 64'(edge_count), 64'd0);
    chk("arst_state", 64'(state), 64'(ST_IDLE));
    gen_on = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_acquire", 64'(state), 64'(ST_ACQUIRE));
    gen_on = 1'b1;
    repeat (50) tick();
    gen_on = 1'b0;
    repeat (8) tick();
    chk("post_rst_period", 64'(period), 64'd10);
    chk("post_rst_edge_count", 64'(edge_count), 64'(exp_edges));
    chk("final_sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
